// File: rtl/fpmad_addnorm_pkg.sv
// Shared single-precision definitions for the FMA add/normalize stage:
// the float_t layout, format constants, flag encodings and operand classifiers.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float_t;

  localparam int          FP_BIAS    = 127;
  localparam logic [7:0]  FP_EXP_MAX = 8'd255;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

  // o_flags bit positions: {invalid, overflow, underflow}
  localparam logic [2:0] FLAG_INVALID   = 3'b100;
  localparam logic [2:0] FLAG_OVERFLOW  = 3'b010;
  localparam logic [2:0] FLAG_UNDERFLOW = 3'b001;

  // Result decided by operand classes alone; carried beside the arithmetic path
  typedef struct packed {
    logic        hit;
    logic [31:0] res;
    logic [2:0]  flags;
  } special_t;

  // Denormals are flushed, so any zero exponent counts as zero
  function automatic logic is_zero(float_t f);
    return f.exp == 8'd0;
  endfunction

  function automatic logic is_inf(float_t f);
    return (f.exp == FP_EXP_MAX) && (f.frac == 23'd0);
  endfunction

  function automatic logic is_nan(float_t f);
    return (f.exp == FP_EXP_MAX) && (f.frac != 23'd0);
  endfunction

endpackage

// File: rtl/fpmad_addnorm_if.sv
// Operand/result bundle of fpmad_addnorm.
// Handshake: valid-only, no ready. A beat transfers on every rising clk edge
// where i_valid=1 (inputs) or o_valid=1 (outputs); the sink must always accept.
// o_res/o_flags hold their previous value whenever o_valid=0.
interface fpmad_addnorm_if;
  logic              i_valid;
  fp_pkg::float_t    i_p;
  fp_pkg::float_t    i_c;
  logic              o_valid;
  fp_pkg::float_t    o_res;
  logic [2:0]        o_flags;

  modport master (output i_valid, i_p, i_c, input o_valid, o_res, o_flags);
  modport slave  (input i_valid, i_p, i_c, output o_valid, o_res, o_flags);
endinterface

// File: rtl/fpmad_addnorm_lzc.sv
// fp_lzc28: combinational 28-bit leading-zero counter; all-zero input gives 28.
module fp_lzc28 (
  input  logic [27:0] a_i,
  output logic [4:0]  cnt_o
);

  // Scan upward so the highest set bit has the final say
  always_comb begin
    cnt_o = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (a_i[i]) cnt_o = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fpmad_addnorm.sv
// fpmad_addnorm: align / add / normalize-round-pack, 3 register stages.
// Build option: define FPMAD_RNE_EN for round-to-nearest-even, otherwise the
// result is truncated (round toward zero). Latency is the same either way.
module fpmad_addnorm
  import fp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fpmad_addnorm_if.slave bus
);

`ifdef FPMAD_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  float_t      p, c;
  logic [23:0] sig_p, sig_c, sig_a, sig_b;
  logic        swap, sign_a, eff_sub;
  logic [7:0]  exp_a, exp_b, exp_diff;
  logic [26:0] b_full, b_shift, b_lost, sig_a27, sig_b27;
  special_t    spec_d;

  assign p     = bus.i_p;
  assign c     = bus.i_c;
  assign sig_p = {~is_zero(p), p.frac};
  assign sig_c = {~is_zero(c), c.frac};

  // S1: put the larger operand in A and shift B right, folding lost bits into S
  always_comb begin
    swap     = (c.exp > p.exp) || ((c.exp == p.exp) && (sig_c > sig_p));
    sign_a   = swap ? c.sign : p.sign;
    exp_a    = swap ? c.exp  : p.exp;
    exp_b    = swap ? p.exp  : c.exp;
    sig_a    = swap ? sig_c  : sig_p;
    sig_b    = swap ? sig_p  : sig_c;
    eff_sub  = p.sign ^ c.sign;
    exp_diff = exp_a - exp_b;
    sig_a27  = {sig_a, 3'b000};
    b_full   = {sig_b, 3'b000};
    b_shift  = b_full >> exp_diff;
    b_lost   = b_full & ~(27'h7FF_FFFF << exp_diff);
    if (exp_diff >= 8'd27) sig_b27 = {26'd0, |sig_b};
    else                   sig_b27 = {b_shift[26:1], b_shift[0] | (|b_lost)};
  end

  // S1: NaN/inf/zero cases that bypass the arithmetic result
  always_comb begin
    spec_d = '0;
    if (is_nan(p) || is_nan(c) || (is_inf(p) && is_inf(c) && (p.sign != c.sign))) begin
      spec_d = '{hit: 1'b1, res: FP_QNAN, flags: FLAG_INVALID};
    end else if (is_inf(p)) begin
      spec_d = '{hit: 1'b1, res: p, flags: 3'b000};
    end else if (is_inf(c)) begin
      spec_d = '{hit: 1'b1, res: c, flags: 3'b000};
    end else if (is_zero(p) && is_zero(c)) begin
      spec_d = '{hit: 1'b1, res: {p.sign & c.sign, 31'd0}, flags: 3'b000};
    end else if (is_zero(p)) begin
      spec_d = '{hit: 1'b1, res: c, flags: 3'b000};
    end else if (is_zero(c)) begin
      spec_d = '{hit: 1'b1, res: p, flags: 3'b000};
    end
  end

  logic        s1_valid_q, s1_sign_q, s1_sub_q;
  logic [7:0]  s1_exp_q;
  logic [26:0] s1_siga_q, s1_sigb_q;
  special_t    s1_spec_q;

  // S1 register: valid always advances, payload loads only on a valid beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_exp_q   <= '0;
      s1_siga_q  <= '0;
      s1_sigb_q  <= '0;
      s1_spec_q  <= '0;
    end else begin
      s1_valid_q <= bus.i_valid;
      if (bus.i_valid) begin
        s1_sign_q <= sign_a;
        s1_sub_q  <= eff_sub;
        s1_exp_q  <= exp_a;
        s1_siga_q <= sig_a27;
        s1_sigb_q <= sig_b27;
        s1_spec_q <= spec_d;
      end
    end
  end

  logic [27:0]        sum_d;
  logic               s2_valid_q, s2_sign_q;
  logic signed [9:0]  s2_exp_q;
  logic [27:0]        s2_sum_q;
  special_t           s2_spec_q;

  // S2: A >= B after the swap, so the subtract never goes negative
  always_comb begin
    sum_d = s1_sub_q ? ({1'b0, s1_siga_q} - {1'b0, s1_sigb_q})
                     : ({1'b0, s1_siga_q} + {1'b0, s1_sigb_q});
  end

  // S2 register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_sum_q   <= '0;
      s2_spec_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_q <= s1_sign_q;
        s2_exp_q  <= $signed({2'b00, s1_exp_q});
        s2_sum_q  <= sum_d;
        s2_spec_q <= s1_spec_q;
      end
    end
  end

  logic [4:0]        lzc;
  logic [27:0]       norm;
  logic [26:0]       n27;
  logic              round_inc;
  logic [24:0]       mant25;
  logic [22:0]       frac_r;
  logic signed [9:0] exp_n, exp_r;
  logic [31:0]       res_d;
  logic [2:0]        flags_d;

  fp_lzc28 u_lzc (.a_i(s2_sum_q), .cnt_o(lzc));

  // S3: the hidden bit sits at sum[26]; shifting left by lzc puts the leading
  // one at bit 27 (lzc=0 on carry-out), so exp = expA + 1 - lzc covers both cases
  always_comb begin
    norm      = s2_sum_q << lzc;
    n27       = {norm[27:2], norm[1] | norm[0]};
    exp_n     = s2_exp_q + 10'sd1 - $signed({5'd0, lzc});
    round_inc = RNE_EN & n27[2] & (n27[1] | n27[0] | n27[3]);
    mant25    = {1'b0, n27[26:3]} + {24'd0, round_inc};
    frac_r    = mant25[24] ? mant25[23:1] : mant25[22:0];
    exp_r     = mant25[24] ? exp_n + 10'sd1 : exp_n;
    res_d     = {s2_sign_q, exp_r[7:0], frac_r};
    flags_d   = 3'b000;
    if (s2_spec_q.hit) begin
      res_d   = s2_spec_q.res;
      flags_d = s2_spec_q.flags;
    end else if (s2_sum_q == 28'd0) begin
      res_d   = 32'd0;
    end else if (exp_r >= 10'sd255) begin
      res_d   = {s2_sign_q, FP_EXP_MAX, 23'd0};
      flags_d = FLAG_OVERFLOW;
    end else if (exp_r <= 10'sd0) begin
      res_d   = {s2_sign_q, 31'd0};
      flags_d = FLAG_UNDERFLOW;
    end
  end

  logic        o_valid_q;
  logic [31:0] o_res_q;
  logic [2:0]  o_flags_q;

  // Output register: result and flags hold while no new beat arrives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid_q <= 1'b0;
      o_res_q   <= '0;
      o_flags_q <= '0;
    end else begin
      o_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        o_res_q   <= res_d;
        o_flags_q <= flags_d;
      end
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_res   = o_res_q;
  assign bus.o_flags = o_flags_q;

endmodule

// File: tb/tb_fpmad_addnorm.sv
// Directed bench for fpmad_addnorm: stimulus pushes expected results into a
// queue, a negedge monitor pops and compares whenever o_valid is seen.
module tb_fpmad_addnorm;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  fpmad_addnorm_if bus();

  fpmad_addnorm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef FPMAD_RNE_EN
  localparam logic [31:0] EXP_GRS    = 32'h3F80_0001;
  localparam logic [31:0] EXP_BORROW = 32'h3F80_0000;
`else
  localparam logic [31:0] EXP_GRS    = 32'h3F80_0000;
  localparam logic [31:0] EXP_BORROW = 32'h3F7F_FFFF;
`endif

  logic [34:0] exp_q[$];
  int          exp_t_q[$];
  logic [31:0] last_res;
  logic [2:0]  last_flags;
  logic [34:0] mon_e;
  int          mon_t;

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // driver tasks
  task automatic send(input logic [31:0] p, input logic [31:0] c,
                      input logic [31:0] res, input logic [2:0] fl);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b1;
    bus.i_p     = p;
    bus.i_c     = c;
    exp_q.push_back({res, fl});
    exp_t_q.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_p     = $urandom;
      bus.i_c     = $urandom;
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      check("reset_o_valid", {31'd0, bus.o_valid}, 32'd0);
      check("reset_o_res", bus.o_res, 32'd0);
      check("reset_o_flags", {29'd0, bus.o_flags}, 32'd0);
      last_res   = 32'd0;
      last_flags = 3'd0;
    end else if (bus.o_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got o_valid=1 res=%h, required no output (cycle %0d)",
                 bus.o_res, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        check("o_res", bus.o_res, mon_e[34:3]);
        check("o_flags", {29'd0, bus.o_flags}, {29'd0, mon_e[2:0]});
        check("latency_cycle", 32'(cyc), 32'(mon_t + 3));
        last_res   = mon_e[34:3];
        last_flags = mon_e[2:0];
      end
    end else begin
      check("hold_o_res", bus.o_res, last_res);
      check("hold_o_flags", {29'd0, bus.o_flags}, {29'd0, last_flags});
    end
  end

  // stimulus
  initial begin
    bus.i_valid = 1'b0;
    bus.i_p     = 32'd0;
    bus.i_c     = 32'd0;
    rst         = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // basic arithmetic, rounding and boundaries
    send(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 3'b000);
    idle(4);
    send(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 3'b000);
    send(32'h3F80_0000, 32'h33C0_0000, EXP_GRS,       3'b000);
    send(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 3'b000);
    send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 3'b010);
    send(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 3'b100);
    send(32'h4000_0000, 32'hBF80_0000, 32'h3F80_0000, 3'b000);
    send(32'hBF80_0000, 32'h4000_0000, 32'h3F80_0000, 3'b000);
    send(32'hC040_0000, 32'h3F80_0000, 32'hC000_0000, 3'b000);
    send(32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000, 3'b000);
    send(32'h3F80_0000, 32'hB080_0000, EXP_BORROW,    3'b000);
    send(32'h0080_0000, 32'h80C0_0000, 32'h8000_0000, 3'b001);
    send(32'h4F80_0000, 32'h3F80_0000, 32'h4F80_0000, 3'b000);
    send(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 3'b000);
    send(32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 3'b000);
    send(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b100);
    send(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 3'b000);
    send(32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 3'b000);
    send(32'h0000_0000, 32'hC0A0_0000, 32'hC0A0_0000, 3'b000);
    idle(5);

    // five-op stream with a bubble after op 2
    send(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000);
    send(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 3'b000);
    idle(1);
    send(32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 3'b000);
    send(32'h4080_0000, 32'hC000_0000, 32'h4000_0000, 3'b000);
    send(32'h4120_0000, 32'h3F80_0000, 32'h4130_0000, 3'b000);
    idle(5);

    // asynchronous reset with operations in flight
    send(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000);
    send(32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 3'b000);
    send(32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 3'b000);
    send(32'h4080_0000, 32'h3F80_0000, 32'h40A0_0000, 3'b000);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    check("pre_reset_o_valid", {31'd0, bus.o_valid}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("async_drop_o_valid", {31'd0, bus.o_valid}, 32'd0);
    check("async_clear_o_res", bus.o_res, 32'd0);
    exp_q.delete();
    exp_t_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(6);
    send(32'h40A0_0000, 32'h3F80_0000, 32'h40C0_0000, 3'b000);
    idle(5);

    // bounded drain
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    check("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
